// File: rtl/b2r_mem_pkg.sv
// Shared constants and types for the black-to-red RAM arbiter.
package b2r_mem_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 12500;
  localparam logic [DATA_W-1:0] OOB_RDATA = 32'hDEAD_BEEF;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   oob;
  } rd_tag_t;

  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
    return addr >= DEPTH_A;
  endfunction

endpackage

// File: rtl/b2r_rr_arbiter2.sv
// Two-way round-robin grant; the pointer always moves to the side that did not win.
module b2r_rr_arbiter2
  import b2r_mem_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  owner_t rr_ptr_q, rr_ptr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= OWN_A;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (req_a && req_b) begin
      if (rr_ptr_q == OWN_A) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
    if (grant_a) begin
      rr_ptr_d = OWN_B;
    end else if (grant_b) begin
      rr_ptr_d = OWN_A;
    end
  end

endmodule

// File: rtl/b2r_mem_arbiter.sv
// Shares the single-port black-to-red RAM between the crypto datapath (A) and the
// control processor (B), with range checking and tagged one-cycle read returns.
module b2r_mem_arbiter
  import b2r_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [1:0]        oob_err,
  input  logic              err_clr
);

  logic              a_req, b_req;
  logic              grant_a, grant_b, any_grant;
  logic              sel_write, sel_oob;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_data;
  rd_tag_t           tag_d, tag_q;
  logic [1:0]        oob_err_d, oob_err_q;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

  // Requests are masked during reset so nothing reaches the RAM and both ports stall.
  b2r_rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a   (a_req & reset_n),
    .req_b   (b_req & reset_n),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign any_grant     = grant_a | grant_b;
  assign a_waitrequest = ~reset_n | (a_req & ~grant_a);
  assign b_waitrequest = ~reset_n | (b_req & ~grant_b);

  always_comb begin
    sel_addr  = a_address;
    sel_be    = a_byteenable;
    sel_wdata = a_writedata;
    sel_write = a_write;
    if (grant_b) begin
      sel_addr  = b_address;
      sel_be    = b_byteenable;
      sel_wdata = b_writedata;
      sel_write = b_write;
    end
    sel_oob = addr_oob(sel_addr);

    mem_chipselect = any_grant & ~(sel_write & sel_oob);
    mem_write      = any_grant & sel_write & ~sel_oob;
    mem_address    = sel_addr;
    mem_byteenable = sel_be;
    mem_writedata  = sel_wdata;

    tag_d.valid = any_grant & ~sel_write;
    tag_d.owner = grant_b ? OWN_B : OWN_A;
    tag_d.oob   = sel_oob;

    // A fresh out-of-range hit takes priority over a clear in the same cycle.
    oob_err_d = (err_clr ? 2'b00 : oob_err_q) |
                {grant_b & sel_oob, grant_a & sel_oob};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q     <= '0;
      oob_err_q <= 2'b00;
    end else begin
      tag_q     <= tag_d;
      oob_err_q <= oob_err_d;
    end
  end

  always_comb begin
    rd_data         = tag_q.oob ? OOB_RDATA : mem_readdata;
    a_readdatavalid = tag_q.valid & (tag_q.owner == OWN_A);
    b_readdatavalid = tag_q.valid & (tag_q.owner == OWN_B);
    a_readdata      = a_readdatavalid ? rd_data : '0;
    b_readdata      = b_readdatavalid ? rd_data : '0;
    oob_err         = oob_err_q;
  end

endmodule
